// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the write-back stage: state encoding,
// architectural constants and the captured EX/MEM bundle layout.
package wb_stage_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned REG_AW             = 5;
    localparam int unsigned LINK_REG           = 31;
    localparam int unsigned WAIT_LIMIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic              reg_we;
        logic              f_reg_we;
        logic [REG_AW-1:0] rw;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   fpu_result;
        logic [XLEN-1:0]   pc;
        logic              mem_to_reg;
        logic              byte_op;
        logic              half_op;
        logic              sign_ext;
        logic              jal;
    } wb_bundle_t;

endpackage

// File: rtl/load_formatter.sv
// Byte/halfword extraction and extension of a loaded word. Memory lanes are
// big-endian: lane 0 is the most significant byte, halfword 0 the upper half.
module load_formatter
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic            byte_op,
    input  logic            half_op,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data_c   = rdata;
        unique case (lane)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        // Low address bit is ignored for halfwords.
        half_sel = lane[1] ? rdata[15:0] : rdata[31:16];
        if (byte_op) begin
            data_c = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
        end else if (half_op) begin
            data_c = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: captures the EX/MEM bundle, waits for load data with a
// bounded timeout, and issues one-cycle GPR/FPR register-file writes.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned LINK_OFFSET = 8,
    parameter int unsigned WAIT_LIMIT  = WAIT_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              reg_we_in,
    input  logic              f_reg_we_in,
    input  logic [REG_AW-1:0] Rw_in,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   fpu_result,
    input  logic [XLEN-1:0]   pc_in,
    input  logic              mem_to_reg,
    input  logic              mem_byte_op,
    input  logic              mem_halfword_op,
    input  logic              mem_sign_ext,
    input  logic              jal_instr,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    output logic              reg_we_out,
    output logic              f_reg_we_out,
    output logic [REG_AW-1:0] Rw_out,
    output logic [XLEN-1:0]   BUS_W,
    output logic [XLEN-1:0]   FBUS_W,
    output logic              Stall_WB,
    output logic              mem_timeout
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    wb_state_e         state, next_state;
    wb_bundle_t        bundle_in, bundle_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              issue, stall, timeout_hit, capture;
    logic [XLEN-1:0]   load_data, gpr_data, fpr_data;
    logic [XLEN-1:0]   last_bus, last_fbus;
    logic [REG_AW-1:0] last_rw;

    always_comb begin
        bundle_in            = '0;
        bundle_in.reg_we     = reg_we_in;
        bundle_in.f_reg_we   = f_reg_we_in;
        bundle_in.rw         = Rw_in;
        bundle_in.alu_result = alu_result;
        bundle_in.fpu_result = fpu_result;
        bundle_in.pc         = pc_in;
        bundle_in.mem_to_reg = mem_to_reg;
        bundle_in.byte_op    = mem_byte_op;
        bundle_in.half_op    = mem_halfword_op;
        bundle_in.sign_ext   = mem_sign_ext;
        bundle_in.jal        = jal_instr;
    end

    load_formatter u_load_formatter (
        .rdata    (mem_rdata),
        .lane     (bundle_q.alu_result[1:0]),
        .byte_op  (bundle_q.byte_op),
        .half_op  (bundle_q.half_op),
        .sign_ext (bundle_q.sign_ext),
        .data_c   (load_data)
    );

    // Next state, stall and write issue; load data is consumed in the rvalid cycle.
    always_comb begin
        next_state  = state;
        issue       = 1'b0;
        stall       = 1'b0;
        timeout_hit = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: next_state = IDLE;
            WRITE: begin
                issue      = 1'b1;
                next_state = IDLE;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    issue      = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                        timeout_hit = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        capture = valid_in && !stall;
        if (capture) begin
            next_state = mem_to_reg ? WAIT : WRITE;
        end
    end

    always_comb begin
        gpr_data = bundle_q.alu_result;
        fpr_data = bundle_q.fpu_result;
        if (bundle_q.jal) begin
            gpr_data = bundle_q.pc + XLEN'(LINK_OFFSET);
        end else if (bundle_q.mem_to_reg) begin
            gpr_data = load_data;
        end
        if (bundle_q.mem_to_reg) begin
            fpr_data = load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bundle_q    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            last_bus    <= '0;
            last_fbus   <= '0;
            last_rw     <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                bundle_q <= bundle_in;
            end
            if (state == WAIT && stall) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            // Buses hold the last issued values between writes.
            if (issue) begin
                last_rw   <= bundle_q.rw;
                last_bus  <= gpr_data;
                last_fbus <= fpr_data;
            end
        end
    end

    assign reg_we_out   = issue && bundle_q.reg_we && (bundle_q.rw != '0);
    assign f_reg_we_out = issue && bundle_q.f_reg_we;
    assign Rw_out       = issue ? bundle_q.rw : last_rw;
    assign BUS_W        = issue ? gpr_data : last_bus;
    assign FBUS_W       = issue ? fpr_data : last_fbus;
    assign Stall_WB     = stall;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected register writes are queued when
// a bundle is driven and compared when the stage issues a write.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int unsigned LOFF = 8;
    localparam int unsigned WLIM = 15;

    logic              clk, reset;
    logic              valid_in, reg_we_in, f_reg_we_in;
    logic [REG_AW-1:0] Rw_in;
    logic [XLEN-1:0]   alu_result, fpu_result, pc_in;
    logic              mem_to_reg, mem_byte_op, mem_halfword_op, mem_sign_ext, jal_instr;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_rvalid;
    logic              reg_we_out, f_reg_we_out;
    logic [REG_AW-1:0] Rw_out;
    logic [XLEN-1:0]   BUS_W, FBUS_W;
    logic              Stall_WB, mem_timeout;

    wb_stage #(.LINK_OFFSET(LOFF), .WAIT_LIMIT(WLIM)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .reg_we_in(reg_we_in),
        .f_reg_we_in(f_reg_we_in), .Rw_in(Rw_in), .alu_result(alu_result),
        .fpu_result(fpu_result), .pc_in(pc_in), .mem_to_reg(mem_to_reg),
        .mem_byte_op(mem_byte_op), .mem_halfword_op(mem_halfword_op),
        .mem_sign_ext(mem_sign_ext), .jal_instr(jal_instr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .reg_we_out(reg_we_out), .f_reg_we_out(f_reg_we_out),
        .Rw_out(Rw_out), .BUS_W(BUS_W), .FBUS_W(FBUS_W), .Stall_WB(Stall_WB),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rwe;
        logic              fwe;
        logic [REG_AW-1:0] rw;
        logic [XLEN-1:0]   bus;
        logic [XLEN-1:0]   fbus;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference load formatting: shift the addressed big-endian lane down.
    function automatic logic [31:0] fmt_model(input logic [31:0] d, input logic [1:0] a,
                                              input logic b, input logic h, input logic s);
        int          sh;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] r;
        sh = 8 * (3 - int'(a));
        by = 8'(d >> sh);
        hw = 16'(d >> (a[1] ? 0 : 16));
        r  = d;
        if (b)      r = s ? {{24{by[7]}}, by} : {24'h0, by};
        else if (h) r = s ? {{16{hw[15]}}, hw} : {16'h0, hw};
        return r;
    endfunction

    // Drive one bundle (captured at the next edge) and queue its expected write.
    task automatic send(input logic rwe, input logic fwe, input logic [4:0] rw,
                        input logic [31:0] alu, input logic [31:0] fpu, input logic [31:0] pc,
                        input logic m2r, input logic bop, input logic hop, input logic sext,
                        input logic jal, input logic [31:0] rdata, input logic completes);
        exp_t        e;
        logic [31:0] ld;
        @(posedge clk); #1;
        valid_in = 1'b1; reg_we_in = rwe; f_reg_we_in = fwe; Rw_in = rw;
        alu_result = alu; fpu_result = fpu; pc_in = pc; mem_to_reg = m2r;
        mem_byte_op = bop; mem_halfword_op = hop; mem_sign_ext = sext; jal_instr = jal;
        ld     = fmt_model(rdata, alu[1:0], bop, hop, sext);
        e.rw   = rw;
        e.rwe  = rwe && (rw != 5'd0);
        e.fwe  = fwe;
        e.bus  = jal ? pc + 32'(LOFF) : (m2r ? ld : alu);
        e.fbus = m2r ? ld : fpu;
        if (completes && (e.rwe || e.fwe)) sb.push_back(e);
    endtask

    task automatic release_in();
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic load_resp(input int waits, input logic [31:0] d);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("stall_wait", 32'(Stall_WB), 32'd1);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1; mem_rdata = d;
        @(negedge clk);
        check("stall_rvalid", 32'(Stall_WB), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rw, input logic [31:0] alu, input logic exp_we);
        send(1'b1, 1'b0, rw, alu, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        release_in();
        @(negedge clk);
        check("alu_we_pulse", 32'(reg_we_out), 32'(exp_we));
        @(negedge clk);
        check("alu_we_off", 32'(reg_we_out), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(reg_we_out), 32'd0);
        check({tag, "_fwe"}, 32'(f_reg_we_out), 32'd0);
        check({tag, "_rw"}, 32'(Rw_out), 32'd0);
        check({tag, "_bus"}, BUS_W, 32'd0);
        check({tag, "_fbus"}, FBUS_W, 32'd0);
        check({tag, "_stall"}, 32'(Stall_WB), 32'd0);
        check({tag, "_tmo"}, 32'(mem_timeout), 32'd0);
    endtask

    // Scoreboard monitor: every issued write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (reg_we_out || f_reg_we_out)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {30'd0, reg_we_out, f_reg_we_out}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rw", 32'(Rw_out), 32'(mon_e.rw));
                check("wb_we", 32'(reg_we_out), 32'(mon_e.rwe));
                check("wb_fwe", 32'(f_reg_we_out), 32'(mon_e.fwe));
                if (mon_e.rwe) check("wb_bus", BUS_W, mon_e.bus);
                if (mon_e.fwe) check("wb_fbus", FBUS_W, mon_e.fbus);
            end
        end
    end

    initial begin
        logic [31:0] rd, ad;
        reset = 1'b1; valid_in = 1'b0; reg_we_in = 1'b0; f_reg_we_in = 1'b0; Rw_in = '0;
        alu_result = '0; fpu_result = '0; pc_in = '0; mem_to_reg = 1'b0; mem_byte_op = 1'b0;
        mem_halfword_op = 1'b0; mem_sign_ext = 1'b0; jal_instr = 1'b0;
        mem_rdata = '0; mem_rvalid = 1'b0;

        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU op: one-cycle write the cycle after capture
        alu_op(5'd5, 32'h12345678, 1'b1);
        check("alu_bus_hold", BUS_W, 32'h12345678);

        // Signed byte load, lane 2, three wait cycles
        send(1'b1, 1'b0, 5'd7, 32'h00001002, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
             32'h0011F233, 1'b1);
        release_in();
        load_resp(3, 32'h0011F233);
        check("sbyte_bus", BUS_W, 32'hFFFFFFF2);

        // Unsigned halfword load, address low bits 3
        send(1'b1, 1'b0, 5'd8, 32'h00002003, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             32'hAAAA8001, 1'b1);
        release_in();
        load_resp(1, 32'hAAAA8001);
        check("uhalf_bus", BUS_W, 32'h00008001);

        // JAL link into register 31
        send(1'b1, 1'b0, 5'(LINK_REG), 32'hDEAD0000, 32'h0, 32'h00000100, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b1, 32'h0, 1'b1);
        release_in();
        @(negedge clk);
        check("jal_bus", BUS_W, 32'h00000108);
        check("jal_rw", 32'(Rw_out), 32'd31);

        // Mixed loads, including FPR targets and zero-wait responses
        for (int i = 0; i < 6; i++) begin
            rd = $urandom;
            ad = $urandom;
            send(1'b1, 1'(i % 2), 5'(i + 10), ad, 32'h0, 32'h0, 1'b1, 1'(i % 3 == 0),
                 1'(i % 3 == 1), 1'($urandom_range(1, 0)), 1'b0, rd, 1'b1);
            release_in();
            load_resp(int'($urandom_range(3, 0)), rd);
        end

        // FPR write to register 0 is allowed
        send(1'b0, 1'b1, 5'd0, 32'h0, 32'h3F800000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0, 1'b1);
        release_in();
        @(negedge clk);
        check("fpr_r0_fwe", 32'(f_reg_we_out), 32'd1);

        // Back-to-back ALU ops: new capture during WRITE
        send(1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0, 1'b1);
        send(1'b1, 1'b0, 5'd4, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0, 1'b1);
        release_in();
        @(negedge clk);
        check("b2b_second_rw", 32'(Rw_out), 32'd4);

        // Load never answered: times out after WLIM stalled cycles
        check("tmo_before", 32'(mem_timeout), 32'd0);
        send(1'b1, 1'b0, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        release_in();
        for (int i = 0; i < int'(WLIM); i++) begin
            @(negedge clk);
            check("tmo_stall", 32'(Stall_WB), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tmo_stall_end", 32'(Stall_WB), 32'd0);
        check("tmo_flag", 32'(mem_timeout), 32'd1);
        alu_op(5'd6, 32'hCAFEF00D, 1'b1);
        check("tmo_sticky", 32'(mem_timeout), 32'd1);

        // Reset while waiting on a load: outputs cleared, load dropped
        send(1'b1, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        release_in();
        @(negedge clk);
        check("rstwait_stall", 32'(Stall_WB), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_in_wait");
        @(posedge clk); #1;
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        @(negedge clk);
        check("post_rst_stall", 32'(Stall_WB), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        // ALU op to r0: no GPR write pulse
        alu_op(5'd0, 32'h77777777, 1'b0);
        alu_op(5'd1, 32'h00000001, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
